// File: rtl/seven_seg_capture.sv
// seven_seg_capture: watches a multiplexed active-low seven-segment bus, debounces each
// digit dwell, decodes patterns to nibbles and reassembles the displayed 16-bit value.
module seven_seg_capture #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic        clk_pi,
    input  logic        rst_pi,
    input  logic [6:0]  seg_pi,
    input  logic [3:0]  an_pi,
    output logic [15:0] num_po,
    output logic        valid_po,
    output logic        err_po,
    output logic [1:0]  digit_po
);
    typedef enum logic [1:0] {IDLE, SETTLE, HELD} state_t;

    state_t      state_q, state_d;
    logic [6:0]  seg_q;
    logic [3:0]  an_q;
    logic [7:0]  cnt_q, cnt_d;
    logic [15:0] slots_q, slots_d, num_q, num_d;
    logic [3:0]  cap_q, cap_d;
    logic        bad_q, bad_d, valid_q, valid_d, err_q, err_d;
    logic [1:0]  digit_q, digit_d;
    logic        change, fire, legal;
    logic [1:0]  idx;
    logic [4:0]  dec;

    // Returns {pattern_ok, nibble}.
    function automatic logic [4:0] decode(input logic [6:0] s);
        case (s)
            7'h40: return 5'h10;
            7'h79: return 5'h11;
            7'h24: return 5'h12;
            7'h30: return 5'h13;
            7'h19: return 5'h14;
            7'h12: return 5'h15;
            7'h02: return 5'h16;
            7'h78: return 5'h17;
            7'h00: return 5'h18;
            7'h18: return 5'h19;
            7'h08: return 5'h1A;
            7'h03: return 5'h1B;
            7'h46: return 5'h1C;
            7'h21: return 5'h1D;
            7'h06: return 5'h1E;
            7'h0E: return 5'h1F;
            default: return 5'h00;
        endcase
    endfunction

    assign change = (seg_pi != seg_q) || (an_pi != an_q);
    assign legal  = (an_q == 4'hE) || (an_q == 4'hD) || (an_q == 4'hB) || (an_q == 4'h7);
    assign idx    = an_q == 4'hE ? 2'd0 : an_q == 4'hD ? 2'd1 : an_q == 4'hB ? 2'd2 : 2'd3;
    assign dec    = decode(seg_q);
    assign fire   = (state_q == SETTLE) && !change && (cnt_d == 8'(SETTLE_CYCLES));

    always_comb begin
        cnt_d   = change ? 8'd0 : (cnt_q == 8'hFF ? cnt_q : cnt_q + 8'd1);
        state_d = state_q;
        slots_d = slots_q;
        num_d   = num_q;
        cap_d   = cap_q;
        bad_d   = bad_q;
        digit_d = digit_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        // A completed frame is judged one edge after its fourth capture.
        if (cap_q == 4'hF) begin
            cap_d   = 4'h0;
            bad_d   = 1'b0;
            valid_d = !bad_q;
            err_d   = bad_q;
            num_d   = bad_q ? num_q : slots_q;
        end
        if (change) begin
            state_d = (an_pi == 4'hF) ? IDLE : SETTLE;
        end else if (fire) begin
            state_d = HELD;
            if (legal) begin
                slots_d[idx*4 +: 4] = dec[3:0];
                cap_d[idx]          = 1'b1;
                bad_d               = bad_d | !dec[4];
                digit_d             = idx;
            end else begin
                err_d = 1'b1;
                cap_d = 4'h0;
                bad_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_pi or posedge rst_pi) begin
        if (rst_pi) begin
            state_q <= IDLE;
            seg_q   <= 7'h7F;
            an_q    <= 4'hF;
            cnt_q   <= 8'd0;
            slots_q <= 16'h0;
            num_q   <= 16'h0;
            cap_q   <= 4'h0;
            bad_q   <= 1'b0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            digit_q <= 2'd0;
        end else begin
            state_q <= state_d;
            seg_q   <= seg_pi;
            an_q    <= an_pi;
            cnt_q   <= cnt_d;
            slots_q <= slots_d;
            num_q   <= num_d;
            cap_q   <= cap_d;
            bad_q   <= bad_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            digit_q <= digit_d;
        end
    end

    assign num_po   = num_q;
    assign valid_po = valid_q;
    assign err_po   = err_q;
    assign digit_po = digit_q;
endmodule

// File: tb/tb_seven_seg_capture.sv
// tb_seven_seg_capture: directed scans of the seven-segment bus with hand-computed results.
module tb_seven_seg_capture;
    logic        clk_pi = 1'b0;
    logic        rst_pi = 1'b1;
    logic [6:0]  seg_pi = 7'h7F;
    logic [3:0]  an_pi  = 4'hF;
    logic [15:0] num_po;
    logic        valid_po, err_po;
    logic [1:0]  digit_po;
    int checks = 0, failures = 0, vcnt = 0, ecnt = 0, v0, e0;
    logic [6:0] seg_lut [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    seven_seg_capture #(.SETTLE_CYCLES(2)) dut (
        .clk_pi(clk_pi), .rst_pi(rst_pi), .seg_pi(seg_pi), .an_pi(an_pi),
        .num_po(num_po), .valid_po(valid_po), .err_po(err_po), .digit_po(digit_po)
    );

    always #5 clk_pi = ~clk_pi;

    always @(negedge clk_pi) begin
        if (valid_po) vcnt++;
        if (err_po) ecnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic hold(input logic [3:0] an, input logic [6:0] seg, input int n);
        an_pi  = an;
        seg_pi = seg;
        repeat (n) @(posedge clk_pi);
        #1;
    endtask

    task automatic show(input int d, input logic [3:0] nib, input int n);
        hold(~(4'b0001 << d), seg_lut[nib], n);
    endtask

    task automatic scan(input logic [15:0] v);
        for (int d = 0; d < 4; d++) show(d, v[d*4 +: 4], 4);
    endtask

    initial begin
        repeat (2) @(posedge clk_pi);
        #1;
        check("rst_num", num_po, 0);
        check("rst_valid", valid_po, 0);
        check("rst_err", err_po, 0);
        check("rst_digit", digit_po, 0);
        rst_pi = 1'b0;
        hold(4'hF, 7'h7F, 2);

        // Capture latency: pair sampled at E+1, captured at E+3.
        show(0, 4'h4, 2);
        check("lat_before", digit_po, 0);
        hold(4'hE, seg_lut[4], 1);
        check("lat_digit0", digit_po, 0);
        hold(4'hE, seg_lut[4], 1);
        show(1, 4'h3, 3);
        check("lat_digit1", digit_po, 1);
        hold(4'hD, seg_lut[3], 1);
        show(2, 4'h2, 4);
        show(3, 4'h1, 4);
        check("f1234_pulse", valid_po, 1);
        check("f1234_num", num_po, 16'h1234);
        hold(4'hF, 7'h7F, 3);
        check("f1234_vcnt", vcnt, 1);
        check("f1234_ecnt", ecnt, 0);

        // Invalid segment pattern on digit2 spoils the frame.
        v0 = vcnt;
        show(0, 4'h4, 4);
        show(1, 4'h3, 4);
        hold(4'hB, 7'h7F, 4);
        show(3, 4'h1, 4);
        check("bad_err_pulse", err_po, 1);
        check("bad_valid", valid_po, 0);
        hold(4'hF, 7'h7F, 3);
        check("bad_ecnt", ecnt, 1);
        check("bad_vcnt", vcnt, v0);
        check("bad_num_hold", num_po, 16'h1234);

        show(3, 4'hA, 4);
        show(2, 4'hB, 4);
        show(1, 4'hC, 4);
        show(0, 4'hD, 4);
        hold(4'hF, 7'h7F, 3);
        check("fABCD_num", num_po, 16'hABCD);
        check("fABCD_vcnt", vcnt, v0 + 1);

        // One-cycle glitch between dwells is ignored.
        v0 = vcnt;
        show(0, 4'h5, 4);
        hold(4'hB, 7'h00, 1);
        show(1, 4'h6, 1);
        check("glitch_digit", digit_po, 0);
        show(1, 4'h6, 3);
        show(2, 4'h7, 4);
        show(3, 4'h8, 4);
        hold(4'hF, 7'h7F, 3);
        check("glitch_num", num_po, 16'h8765);
        check("glitch_vcnt", vcnt, v0 + 1);

        // Illegal anode discards the partial frame.
        v0 = vcnt;
        e0 = ecnt;
        show(2, 4'h9, 4);
        show(3, 4'h9, 4);
        hold(4'hC, 7'h40, 3);
        check("illegal_err", err_po, 1);
        hold(4'hC, 7'h40, 1);
        show(0, 4'hF, 4);
        show(1, 4'hF, 4);
        hold(4'hF, 7'h7F, 3);
        check("illegal_no_valid", vcnt, v0);
        check("illegal_ecnt", ecnt, e0 + 1);
        scan(16'h00FF);
        hold(4'hF, 7'h7F, 3);
        check("f00FF_num", num_po, 16'h00FF);
        check("f00FF_vcnt", vcnt, v0 + 1);

        // Blank gap and a long dwell still give one frame.
        v0 = vcnt;
        e0 = ecnt;
        show(0, 4'h1, 20);
        show(1, 4'h2, 4);
        hold(4'hF, 7'h7F, 10);
        show(2, 4'h3, 4);
        show(3, 4'h4, 4);
        hold(4'hF, 7'h7F, 3);
        check("blank_num", num_po, 16'h4321);
        check("blank_vcnt", vcnt, v0 + 1);
        check("blank_ecnt", ecnt, e0);

        // Reset mid-frame.
        v0 = vcnt;
        e0 = ecnt;
        show(0, 4'hA, 4);
        show(1, 4'h5, 4);
        #2 rst_pi = 1'b1;
        #1;
        check("mrst_num", num_po, 0);
        check("mrst_digit", digit_po, 0);
        check("mrst_valid", valid_po, 0);
        repeat (2) @(posedge clk_pi);
        #1 rst_pi = 1'b0;
        hold(4'hF, 7'h7F, 2);
        check("mrst_no_pulse", vcnt + ecnt, v0 + e0);
        scan(16'h5A5A);
        hold(4'hF, 7'h7F, 3);
        check("f5A5A_num", num_po, 16'h5A5A);
        check("f5A5A_vcnt", vcnt, v0 + 1);
        check("f5A5A_ecnt", ecnt, e0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/seven_seg_capture.md
# seven_seg_capture

Receive-side counterpart of the seven-segment display driver: monitors the multiplexed, active-low segment/anode bus, debounces each digit dwell, decodes segment patterns back to hex nibbles, and reassembles the 16-bit displayed value. Used as a loopback checker and as a capture front-end for external displays driven with the same scan protocol. It sits on the board-level seg/an nets, or on a looped-back driver output, in the same clock domain as the driver.

## Interface
- SETTLE_CYCLES, 2: consecutive cycles an (anode) and seg (segment) pair must be unchanged before capture; legal range 1..255.
- clk_pi  in  1  system clock, all logic on rising edge.
- rst_pi  in  1  asynchronous, active-high reset.
- seg_pi  in  7  segment bus, active low; bit0=top, 1=upper-right, 2=lower-right, 3=bottom, 4=lower-left, 5=upper-left, 6=middle.
- an_pi  in  4  anode enables, active low; an_pi[i] low selects digit i (digit0 = num[3:0]).
- num_po  out  16  last complete, error-free reconstructed value.
- valid_po  out  1  one-cycle pulse when num_po updates.
- err_po  out  1  one-cycle pulse on a discarded frame or illegal anode code.
- digit_po  out  2  index of most recently captured digit (debug).

## Operation
- Decode (active-low seg_pi to nibble): 40→0, 79→1, 24→2, 30→3, 19→4, 12→5, 02→6, 78→7, 00→8, 18→9, 08→A, 03→b, 46→C, 21→d, 06→E, 0E→F (hex). Any other pattern is invalid.
- Anode classes: 1110/1101/1011/0111 → digit 0/1/2/3; 1111 → blank (ignored, no capture, no error); any other code → illegal.
- Input stage: seg_pi/an_pi registered each cycle into seg_q/an_q; stability counter cleared when inputs differ from seg_q/an_q, else incremented (saturating).
- FSM states:
  - IDLE: waiting for a non-blank pair; go to SETTLE on any change.
  - SETTLE: counting; any change restarts the count; on reaching SETTLE_CYCLES go to HELD and perform one capture.
  - HELD: pair already captured; stay until inputs change, then go to SETTLE (or IDLE if the new anode is 1111).
- Capture, once per dwell:
  - Digit slot i ← decoded nibble; captured[i] ← 1.
  - Invalid pattern: captured[i] ← 1 and frame_bad ← 1.
  - Recapturing a slot already set before the frame completes overwrites it; latest value wins.
- Frame complete when captured == 4'b1111, evaluated the edge after the capture:
  - frame_bad = 0: num_po ← {slot3, slot2, slot1, slot0}; valid_po = 1.
  - frame_bad = 1: num_po holds; err_po = 1.
  - Either case: captured ← 0 and frame_bad ← 0.
- Illegal anode, once stable SETTLE_CYCLES: err_po = 1, captured ← 0, frame_bad ← 0, slots untouched, FSM → HELD.
- valid_po and err_po are never asserted in the same cycle.

## Timing
- Reset (async assert, sync release): num_po = 0, valid_po = 0, err_po = 0, digit_po = 0, captured = 0, frame_bad = 0, counter = 0, FSM = IDLE.
- New pair first present at edge E → registered at E+1 → captured at edge E+1+SETTLE_CYCLES (digit_po updates there).
- valid_po/err_po asserted for exactly the one cycle following the edge after the fourth capture; num_po updates in that same cycle.
- Minimum digit dwell for capture: SETTLE_CYCLES+1 cycles; shorter pulses (glitches) are ignored entirely and restart counting.
- Digits may arrive in any order; frame boundary is purely captured == 1111.
- Reset mid-frame discards partial captures; no valid_po/err_po is emitted for the partial frame.
- Counter saturates; arbitrarily long dwells produce exactly one capture.

## Test plan
- Scan digit0 seg 19/an 1110, digit1 30/1101, digit2 24/1011, digit3 79/0111, 4 cycles each, SETTLE_CYCLES=2 → num_po = 0x1234, one valid_po pulse, err_po stays 0.
- Same scan with digit2 seg = 7F → err_po single pulse, num_po holds 0x1234 from the prior frame, next clean frame 0xABCD (08, 03, 46, 21 in digit order 3..0) → num_po = 0xABCD.
- Insert a 1-cycle glitch an 1011 seg 00 between dwells → no capture, digit_po unchanged; frame still completes correctly.
- an_pi = 1100 held 4 cycles mid-frame → err_po pulse, partial frame discarded; next full scan of 0x00FF yields valid_po with num_po = 0x00FF.
- an_pi = 1111 for 10 cycles between digits → ignored; frame completes normally.
- Assert rst_pi after two digits captured → all outputs 0 immediately; after release, a full scan of 0x5A5A produces exactly one valid_po.
